// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life display path: grid geometry,
// scanner state encoding and the row-off drive level.
package gol_pkg;

  localparam int GRID_ROWS  = 8;
  localparam int GRID_COLS  = 8;
  localparam int GRID_CELLS = 64;

  localparam logic [7:0] ROW_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BLANKING,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/gol_popcount.sv
// Combinational population count of a 64-cell grid: per-row counts feed a
// small adder tree. The caller registers the result.
module gol_popcount
  import gol_pkg::*;
(
  input  logic [GRID_CELLS-1:0] bits,
  output logic [6:0]            count
);

  logic [3:0] row_cnt [GRID_ROWS];
  logic [4:0] pair    [4];
  logic [5:0] quad    [2];

  // Count live cells in each 8-cell row.
  always_comb begin
    for (int r = 0; r < GRID_ROWS; r++) begin
      row_cnt[r] = '0;
      for (int c = 0; c < GRID_COLS; c++) begin
        row_cnt[r] = row_cnt[r] + {3'b000, bits[r*GRID_COLS + c]};
      end
    end
  end

  // Reduce the eight row counts pairwise: 8 -> 4 -> 2 -> 1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pair[i] = {1'b0, row_cnt[2*i]} + {1'b0, row_cnt[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      quad[i] = {1'b0, pair[2*i]} + {1'b0, pair[2*i+1]};
    end
    count = {1'b0, quad[0]} + {1'b0, quad[1]};
  end

endmodule

// File: rtl/grid_scanner.sv
// Drives an 8x8 LED matrix from a frame snapshot of the live grid, one row
// at a time with optional blanking between rows, and reports the live-cell
// count of the frame being displayed.
module grid_scanner
  import gol_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  hold,
  input  logic [GRID_CELLS-1:0] grid,
  output logic [7:0]            row_n,
  output logic [7:0]            col,
  output logic                  frame_start,
  output logic [6:0]            live_count
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  scan_state_t           state;
  logic [2:0]            r;
  logic [2:0]            r_inc;
  logic [CW-1:0]         cnt;
  logic [GRID_CELLS-1:0] snap;
  logic [GRID_CELLS-1:0] snap_nxt;
  logic [6:0]            pop;

  // The snapshot is only replaced at the end of an enabled LOAD cycle, so
  // grid changes at any other time never reach the display.
  assign snap_nxt = (state == LOAD && en && !hold) ? grid : snap;
  assign r_inc    = r + 3'd1;

  // Count is taken from the value the snapshot is about to hold, so it lines
  // up with the new frame from the first cycle after LOAD.
  gol_popcount u_popcount (
    .bits  (snap_nxt),
    .count (pop)
  );

  // Snapshot and live-count registers.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      snap       <= '0;
      live_count <= '0;
    end else begin
      snap       <= snap_nxt;
      live_count <= pop;
    end
  end

  // Scan FSM; outputs are set on the transition into each state so that
  // they are registered and valid for the whole state.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      cnt         <= '0;
      row_n       <= ROW_OFF;
      col         <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      state       <= IDLE;
      r           <= '0;
      cnt         <= '0;
      row_n       <= ROW_OFF;
      col         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          state       <= LOAD;
          frame_start <= 1'b1;
          row_n       <= ROW_OFF;
          col         <= '0;
        end
        LOAD: begin
          r   <= '0;
          cnt <= '0;
          if (BLANK == 0) begin
            state <= SHOW;
            row_n <= ~8'h01;
            col   <= snap_nxt[7:0];
          end else begin
            state <= BLANKING;
            row_n <= ROW_OFF;
            col   <= '0;
          end
        end
        BLANKING: begin
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            row_n <= ~(8'b1 << r);
            col   <= snap[{r, 3'b000} +: 8];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            if (r == 3'd7) begin
              state       <= LOAD;
              frame_start <= 1'b1;
              row_n       <= ROW_OFF;
              col         <= '0;
            end else begin
              r <= r_inc;
              if (BLANK == 0) begin
                state <= SHOW;
                row_n <= ~(8'b1 << r_inc);
                col   <= snap[{r_inc, 3'b000} +: 8];
              end else begin
                state <= BLANKING;
                row_n <= ROW_OFF;
                col   <= '0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          row_n <= ROW_OFF;
          col   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/grid_scanner.md
# grid_scanner

Display-side reader for the Game of Life datapath. It takes the 64-bit `grid` word produced by `DATAPATH` and drives an 8x8 LED matrix one row at a time. At each frame boundary it captures a tear-free snapshot of the grid, adds blanking between rows to prevent ghosting, and reports the live-cell count of the displayed frame. It sits between `DATAPATH.grid` and the board's row/column drivers.

## Interface
- `DWELL`, 1000, cycles each row stays lit; legal range ≥1.
- `BLANK`, 4, blanking cycles before each row; legal range ≥0, where 0 means no blanking.

- `clka`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  scan enable; low forces outputs off.
- `hold`  in  1  high suppresses snapshot recapture, freezing the displayed frame.
- `grid`  in  64  live grid; cell at row r, column c is `grid[8*r+c]`.
- `row_n`  out  8  row select; active-low one-hot, `8'hFF` when off.
- `col`  out  8  column data for the selected row; active-high, `col[c]` = cell (r,c).
- `frame_start`  out  1  one-cycle pulse in the LOAD cycle of each frame.
- `live_count`  out  7  popcount of the current snapshot, 0..64.

## Operation
- States: IDLE, LOAD, BLANKING, SHOW. Row index `r` is 3 bits. Dwell/blank counter width is `$clog2(max(DWELL,BLANK)+1)`.
- IDLE:
  - `row_n=8'hFF`, `col=0`.
  - `en=1` sampled → LOAD.
- LOAD, one cycle:
  - `frame_start=1`.
  - `snap<=grid` unless `hold=1`.
  - `r<=0`.
  - Next state is BLANKING, or SHOW if `BLANK==0`.
- BLANKING:
  - `row_n=8'hFF`, `col=0` for `BLANK` cycles, then SHOW.
- SHOW:
  - `row_n=~(8'b1<<r)`, `col=snap[8*r +: 8]` for `DWELL` cycles.
  - At the end of the row, if `r<7`: `r<=r+1`, then BLANKING (or SHOW if `BLANK==0`).
  - At the end of the row, if `r==7`: LOAD.
- `en=0` sampled in any state → IDLE next cycle, outputs off. Re-enabling always restarts at LOAD, row 0.
- `hold=1` with no prior capture shows the reset snapshot (all zero).
- `grid` changes outside LOAD never affect the displayed frame.
- `live_count` is registered from `popcount(snap)`. It updates the cycle after the snapshot changes and is constant for the rest of the frame.

## Timing
- Reset values:
  - `row_n=8'hFF`, `col=0`, `frame_start=0`, `live_count=0`.
  - `snap=0`, state IDLE, `r=0`.
- Reset mid-frame: the next cycle shows the reset values.
- `en` rises and is sampled at edge t: LOAD is active in cycle t+1, and the first BLANKING/SHOW cycle is t+2.
- Frame period with `en` held high is `1 + 8*(BLANK+DWELL)` cycles. `frame_start` pulses exactly once per period.
- All outputs are registered; no combinational path from inputs to outputs.
- `live_count` latency: 1 cycle after LOAD.
- `en` and `hold` are sampled every cycle. `hold` matters only in LOAD.

## Structure
- Package `gol_pkg` holds:
  - `GRID_ROWS=8`, `GRID_COLS=8`, `GRID_CELLS=64`.
  - Scanner state enum `scan_state_t`.
  - Row-off constant `ROW_OFF=8'hFF`.
- One sub-module, `gol_popcount`: combinational 64-bit to 7-bit adder tree, registered in the parent. The same unit is reusable later for population statistics in `DATAPATH`.

## Test plan
Parameters for all cases: `DWELL=3`, `BLANK=1`, giving a 33-cycle frame.
1. Reset: `rst_n=0` for 2 cycles with `en=1` → `row_n=8'hFF`, `col=0`, `frame_start=0`, `live_count=0`. LOAD occurs in the cycle after `rst_n` rises.
2. Basic frame: `grid` = row0 `8'h81`, row7 `8'h3C`, other rows 0; `en=1`.
   - One `frame_start` pulse.
   - 1 blank cycle, then `row_n=8'hFE`, `col=8'h81` for 3 cycles.
   - ... `row_n=8'h7F`, `col=8'h3C`.
   - `live_count=6` from the cycle after LOAD.
   - Next `frame_start` follows 33 cycles after the first.
3. Tear-free: change `grid` row0 to `8'hFF` while row 2 is showing → remaining rows of this frame are unchanged, and the next frame shows `8'hFF` with `live_count=12`.
4. Hold: `hold=1` across two LOADs while `grid` changes → both frames display the old snapshot and `live_count` is unchanged.
5. Enable drop: `en=0` during a SHOW of row 3 → next cycle `row_n=8'hFF`, `col=0`. `en=1` again → `frame_start`, then row 0 is shown.
6. Extremes: `grid=64'hFFFF_FFFF_FFFF_FFFF` → `live_count=64`, every row shows `col=8'hFF`. `grid=0` → `live_count=0`, `col=0` on all rows.
